// File: rtl/clock_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clock_pkg
// Description : Shared encodings for the digital-clock mode/time-set control:
//               mode state encodings, display field selection and digit
//               blink masks, plus small helpers for the mode sequence and the
//               blink mask lookup.
// Revision    : 1.0 - initial release
// ============================================================================
package clock_pkg;

  typedef enum logic [1:0] {
    MODE_RUN      = 2'd0,
    MODE_SET_HOUR = 2'd1,
    MODE_SET_MIN  = 2'd2,
    MODE_SET_SEC  = 2'd3
  } mode_e;

  localparam logic DISP_HHMM = 1'b0;
  localparam logic DISP_MMSS = 1'b1;

  localparam logic [3:0] MASK_LEFT  = 4'b1100;
  localparam logic [3:0] MASK_RIGHT = 4'b0011;
  localparam logic [3:0] MASK_NONE  = 4'b0000;

  // Mode button cycles through the four states in a fixed ring.
  function automatic mode_e next_mode(input mode_e m);
    mode_e r;
    unique case (m)
      MODE_RUN:      r = MODE_SET_HOUR;
      MODE_SET_HOUR: r = MODE_SET_MIN;
      MODE_SET_MIN:  r = MODE_SET_SEC;
      default:       r = MODE_RUN;
    endcase
    return r;
  endfunction

  // Digits being edited blank while the blink phase is high.
  function automatic logic [3:0] blink_mask_for(input mode_e m, input logic phase);
    logic [3:0] r;
    r = MASK_NONE;
    if (phase) begin
      unique case (m)
        MODE_SET_HOUR: r = MASK_LEFT;
        MODE_SET_MIN:  r = MASK_RIGHT;
        MODE_SET_SEC:  r = MASK_RIGHT;
        default:       r = MASK_NONE;
      endcase
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/time_set_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : time_set_ctrl_if
// Description : Bundles the time-set controller's functional signals.
//   Controller inputs : sec_tick (1 Hz pulse), btn_mode, btn_inc (raw buttons)
//   Controller outputs: mode[1:0], sec_en, hour_inc, min_inc, sec_clr,
//                       display_sel, blink_mask[3:0]
//   master : the side that drives ticks/buttons and observes commands
//   slave  : the controller itself
// Revision    : 1.0 - initial release
// ============================================================================
interface time_set_ctrl_if;
  logic       sec_tick;
  logic       btn_mode;
  logic       btn_inc;
  logic [1:0] mode;
  logic       sec_en;
  logic       hour_inc;
  logic       min_inc;
  logic       sec_clr;
  logic       display_sel;
  logic [3:0] blink_mask;

  modport master (
    output sec_tick, btn_mode, btn_inc,
    input  mode, sec_en, hour_inc, min_inc, sec_clr, display_sel, blink_mask
  );

  modport slave (
    input  sec_tick, btn_mode, btn_inc,
    output mode, sec_en, hour_inc, min_inc, sec_clr, display_sel, blink_mask
  );
endinterface
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// Module      : btn_debounce
// Description : Push-button conditioner: 2-flop synchronizer, counter-based
//               debounce and a one-cycle pulse on the debounced rising edge.
//   clk     : system clock
//   rst     : synchronous active-high reset
//   i_btn   : raw asynchronous button level
//   o_level : debounced level
//   o_press : one-cycle pulse, registered, after debounced level rises
// Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1024
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic i_btn,
  output logic      o_level,
  output logic      o_press
);

  localparam logic [15:0] C_CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);

  logic        r_sync1;
  logic        r_sync2;
  logic        r_level;
  logic        r_level_q;
  logic        r_press;
  logic [15:0] r_cnt;

  logic w_differ;
  logic w_accept;

  assign w_differ = r_sync2 ^ r_level;
  // Levels have disagreed for DEBOUNCE_CYCLES consecutive cycles.
  assign w_accept = w_differ && (r_cnt == C_CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_level   <= 1'b0;
      r_level_q <= 1'b0;
      r_press   <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_sync1   <= i_btn;
      r_sync2   <= r_sync1;
      if (!w_differ) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_level <= r_sync2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 16'd1;
      end
      r_level_q <= r_level;
      r_press   <= r_level & ~r_level_q;
    end
  end

  assign o_level = r_level;
  assign o_press = r_press;

endmodule
`default_nettype wire

// File: rtl/time_set_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : time_set_ctrl
// Description : Mode and time-setting controller for the digital clock.
//               Passes the 1 Hz tick through in RUN, pauses it while setting,
//               converts mode/inc buttons into one-cycle datapath commands
//               (with auto-repeat on a held inc button) and drives the
//               display field select and digit blink mask.
//   clock : system clock, rising edge
//   reset : synchronous active-high reset
//   bus   : slave side of time_set_ctrl_if (tick, buttons in; mode,
//           command pulses, display_sel, blink_mask out; all registered)
// Revision    : 1.0 - initial release
// ============================================================================
module time_set_ctrl
  import clock_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1024,
  parameter int REPEAT_CYCLES   = 32768
) (
  input  wire logic       clock,
  input  wire logic       reset,
  time_set_ctrl_if.slave  bus
);

  localparam logic [19:0] C_REP_LAST = 20'(REPEAT_CYCLES - 1);

  // Button conditioning
  logic w_mode_level;
  logic w_mode_press;
  logic w_inc_level;
  logic w_inc_press;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_mode (
    .clk     (clock),
    .rst     (reset),
    .i_btn   (bus.btn_mode),
    .o_level (w_mode_level),
    .o_press (w_mode_press)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_inc (
    .clk     (clock),
    .rst     (reset),
    .i_btn   (bus.btn_inc),
    .o_level (w_inc_level),
    .o_press (w_inc_press)
  );

  // Registers
  mode_e       r_state;
  logic        r_phase;
  logic        r_rep_active;
  logic [19:0] r_rep_cnt;
  logic        r_sec_en;
  logic        r_hour_inc;
  logic        r_min_inc;
  logic        r_sec_clr;
  logic        r_disp_sel;
  logic [3:0]  r_mask;

  // Next-state / next-output values
  mode_e      w_state_next;
  logic       w_phase_next;
  logic       w_in_set;
  logic       w_rep_fire;
  logic       w_inc_evt;
  logic       w_sec_en_d;
  logic       w_hour_inc_d;
  logic       w_min_inc_d;
  logic       w_sec_clr_d;
  logic       w_disp_sel_d;
  logic [3:0] w_mask_d;

  assign w_in_set   = (r_state != MODE_RUN);
  // The mode button is unused beyond its press pulse.
  logic w_unused;
  assign w_unused   = w_mode_level;

  assign w_rep_fire = r_rep_active && w_inc_level && w_in_set &&
                      (r_rep_cnt == C_REP_LAST);

  // A mode press in the same cycle swallows any inc event.
  assign w_inc_evt  = w_in_set && !w_mode_press && (w_inc_press || w_rep_fire);

  // FSM state register
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= MODE_RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next state and next registered outputs
  always_comb begin
    w_state_next = r_state;
    w_phase_next = r_phase;
    w_sec_en_d   = 1'b0;
    w_hour_inc_d = 1'b0;
    w_min_inc_d  = 1'b0;
    w_sec_clr_d  = 1'b0;

    if (w_mode_press) begin
      w_state_next = next_mode(r_state);
    end

    // Tick gating uses the current state: a tick on RUN->SET_HOUR still
    // counts, a tick on SET_SEC->RUN is dropped.
    w_sec_en_d = (r_state == MODE_RUN) && bus.sec_tick;

    unique case (r_state)
      MODE_SET_HOUR: w_hour_inc_d = w_inc_evt;
      MODE_SET_MIN:  w_min_inc_d  = w_inc_evt;
      MODE_SET_SEC:  w_sec_clr_d  = w_inc_evt;
      default: ;
    endcase

    if (w_state_next == MODE_RUN) begin
      w_phase_next = 1'b0;
    end else if (w_in_set && bus.sec_tick) begin
      w_phase_next = ~r_phase;
    end

    // Display outputs follow the state/phase they will be registered with.
    w_mask_d     = blink_mask_for(w_state_next, w_phase_next);
    w_disp_sel_d = (w_state_next == MODE_SET_SEC) ? DISP_MMSS : DISP_HHMM;
  end

  // Auto-repeat counter: armed by an inc press in a SET state, fires every
  // REPEAT_CYCLES while the debounced inc level stays high.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rep_active <= 1'b0;
      r_rep_cnt    <= '0;
    end else if (!w_in_set || w_mode_press || !w_inc_level) begin
      r_rep_active <= 1'b0;
      r_rep_cnt    <= '0;
    end else if (w_inc_press) begin
      r_rep_active <= 1'b1;
      r_rep_cnt    <= '0;
    end else if (r_rep_active) begin
      if (r_rep_cnt == C_REP_LAST) begin
        r_rep_cnt <= '0;
      end else begin
        r_rep_cnt <= r_rep_cnt + 20'd1;
      end
    end
  end

  // Output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      r_phase    <= 1'b0;
      r_sec_en   <= 1'b0;
      r_hour_inc <= 1'b0;
      r_min_inc  <= 1'b0;
      r_sec_clr  <= 1'b0;
      r_disp_sel <= DISP_HHMM;
      r_mask     <= MASK_NONE;
    end else begin
      r_phase    <= w_phase_next;
      r_sec_en   <= w_sec_en_d;
      r_hour_inc <= w_hour_inc_d;
      r_min_inc  <= w_min_inc_d;
      r_sec_clr  <= w_sec_clr_d;
      r_disp_sel <= w_disp_sel_d;
      r_mask     <= w_mask_d;
    end
  end

  assign bus.mode        = r_state;
  assign bus.sec_en      = r_sec_en;
  assign bus.hour_inc    = r_hour_inc;
  assign bus.min_inc     = r_min_inc;
  assign bus.sec_clr     = r_sec_clr;
  assign bus.display_sel = r_disp_sel;
  assign bus.blink_mask  = r_mask;

endmodule
`default_nettype wire

// File: tb/tb_time_set_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_time_set_ctrl
// Description : Directed self-checking bench for time_set_ctrl with
//               DEBOUNCE_CYCLES=4 and REPEAT_CYCLES=8. A held raw button
//               press reaches the mode/command outputs 8 cycles after it is
//               applied.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_time_set_ctrl;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  time_set_ctrl_if bus();

  time_set_ctrl #(
    .DEBOUNCE_CYCLES (4),
    .REPEAT_CYCLES   (8)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full mode press: hold 8 cycles (mode changes on the 8th), then release.
  task automatic mode_press();
    bus.btn_mode = 1'b1;
    cyc(8);
    bus.btn_mode = 1'b0;
    cyc(8);
  endtask

  task automatic tick();
    bus.sec_tick = 1'b1;
    cyc(1);
    bus.sec_tick = 1'b0;
  endtask

  initial begin
    int n_pulse;
    int n_rep;
    int rep_pos [4];

    bus.sec_tick = 1'b0;
    bus.btn_mode = 1'b0;
    bus.btn_inc  = 1'b0;
    reset        = 1'b1;
    cyc(3);
    check("rst_mode", bus.mode, 0);
    check("rst_mask", bus.blink_mask, 0);
    check("rst_disp", bus.display_sel, 0);
    check("rst_pulses", {bus.sec_en, bus.hour_inc, bus.min_inc, bus.sec_clr}, 0);
    reset = 1'b0;
    cyc(2);

    // RUN pass-through: each tick becomes sec_en one cycle later
    for (int k = 0; k < 3; k++) begin
      tick();
      check("run_sec_en", bus.sec_en, 1);
      cyc(1);
      check("run_sec_en_off", bus.sec_en, 0);
    end
    check("run_mode", bus.mode, 0);
    check("run_mask", bus.blink_mask, 0);

    // Glitch of 3 cycles is rejected
    bus.btn_mode = 1'b1;
    cyc(3);
    bus.btn_mode = 1'b0;
    cyc(12);
    check("glitch_mode", bus.mode, 0);

    // Debounce latency: mode changes exactly 8 cycles after the rise
    bus.btn_mode = 1'b1;
    cyc(7);
    check("lat_mode_7", bus.mode, 0);
    cyc(1);
    check("lat_mode_8", bus.mode, 1);
    bus.btn_mode = 1'b0;
    cyc(8);
    check("lat_mode_hold", bus.mode, 1);

    // SET_HOUR: one inc press -> one hour_inc
    bus.btn_inc = 1'b1;
    cyc(7);
    check("hour_inc_pre", bus.hour_inc, 0);
    cyc(1);
    check("hour_inc_pulse", bus.hour_inc, 1);
    bus.btn_inc = 1'b0;
    cyc(1);
    check("hour_inc_off", bus.hour_inc, 0);
    n_pulse = 0;
    for (int i = 0; i < 12; i++) begin
      cyc(1);
      n_pulse += int'(bus.hour_inc);
    end
    check("hour_inc_no_rep", n_pulse, 0);

    // Ticks paused in SET, blink toggles
    tick();
    check("set_sec_en_drop", bus.sec_en, 0);
    check("hour_blink_on", bus.blink_mask, 4'b1100);
    check("hour_disp", bus.display_sel, 0);
    cyc(1);
    check("hour_blink_hold", bus.blink_mask, 4'b1100);
    tick();
    check("hour_blink_off", bus.blink_mask, 0);
    check("set_sec_en_drop2", bus.sec_en, 0);

    // SET_MIN with auto-repeat
    mode_press();
    check("mode_min", bus.mode, 2);
    for (int i = 0; i < 4; i++) rep_pos[i] = -1;
    n_rep = 0;
    bus.btn_inc = 1'b1;
    for (int i = 1; i <= 50; i++) begin
      cyc(1);
      if (bus.min_inc) begin
        if (n_rep < 4) rep_pos[n_rep] = i;
        n_rep++;
      end
      if (i == 32) bus.btn_inc = 1'b0;
    end
    check("rep_count", n_rep, 4);
    check("rep_pos0", rep_pos[0], 8);
    check("rep_pos1", rep_pos[1], 16);
    check("rep_pos2", rep_pos[2], 24);
    check("rep_pos3", rep_pos[3], 32);

    // SET_SEC: display MM:SS, blink right pair, inc clears seconds
    mode_press();
    check("mode_sec", bus.mode, 3);
    check("sec_disp", bus.display_sel, 1);
    check("sec_mask0", bus.blink_mask, 0);
    tick();
    check("sec_blink_on", bus.blink_mask, 4'b0011);
    tick();
    check("sec_blink_off", bus.blink_mask, 0);
    check("sec_disp2", bus.display_sel, 1);
    bus.btn_inc = 1'b1;
    cyc(8);
    check("sec_clr_pulse", bus.sec_clr, 1);
    bus.btn_inc = 1'b0;
    cyc(1);
    check("sec_clr_off", bus.sec_clr, 0);
    cyc(10);

    // Tick coinciding with SET_SEC -> RUN is dropped
    bus.btn_mode = 1'b1;
    cyc(7);
    bus.sec_tick = 1'b1;
    cyc(1);
    bus.sec_tick = 1'b0;
    check("wrap_mode", bus.mode, 0);
    check("wrap_tick_drop", bus.sec_en, 0);
    check("wrap_disp", bus.display_sel, 0);
    bus.btn_mode = 1'b0;
    cyc(8);

    // Tick coinciding with RUN -> SET_HOUR still counts
    bus.btn_mode = 1'b1;
    cyc(7);
    bus.sec_tick = 1'b1;
    cyc(1);
    bus.sec_tick = 1'b0;
    check("enter_mode", bus.mode, 1);
    check("enter_tick_kept", bus.sec_en, 1);
    check("enter_mask", bus.blink_mask, 0);
    bus.btn_mode = 1'b0;
    cyc(8);

    // Simultaneous mode + inc in SET_HOUR: mode wins
    bus.btn_mode = 1'b1;
    bus.btn_inc  = 1'b1;
    cyc(8);
    check("simul_mode", bus.mode, 2);
    check("simul_no_hour", bus.hour_inc, 0);
    n_pulse = 0;
    for (int i = 0; i < 12; i++) begin
      cyc(1);
      n_pulse += int'(bus.hour_inc) + int'(bus.min_inc);
      if (i == 0) begin
        bus.btn_mode = 1'b0;
        bus.btn_inc  = 1'b0;
      end
    end
    check("simul_no_inc", n_pulse, 0);

    // Blink in SET_SEC, then reset mid-set
    mode_press();
    check("mode_sec2", bus.mode, 3);
    tick();
    check("sec2_blink_on", bus.blink_mask, 4'b0011);
    reset = 1'b1;
    cyc(1);
    check("midrst_mode", bus.mode, 0);
    check("midrst_mask", bus.blink_mask, 0);
    check("midrst_disp", bus.display_sel, 0);
    reset = 1'b0;
    cyc(2);

    // Inc presses ignored in RUN
    n_pulse = 0;
    bus.btn_inc = 1'b1;
    for (int i = 0; i < 24; i++) begin
      cyc(1);
      n_pulse += int'(bus.hour_inc) + int'(bus.min_inc) + int'(bus.sec_clr);
    end
    bus.btn_inc = 1'b0;
    check("run_inc_ignored", n_pulse, 0);
    check("run_mode_end", bus.mode, 0);
    cyc(8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
